// File: rtl/tl_async_queue_source_param.sv
// Source half of a TileLink async clock crossing: a DEPTH-entry register ring
// with a Gray-coded write index, a synchronised read index, occupancy and watermark.
module tl_async_queue_source_param #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int SYNC   = 3,
   parameter int HWM    = DEPTH - 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          io_enq_valid,
   output logic                          io_enq_ready,
   input  logic [DATA_W-1:0]             io_enq_bits,
   output logic [DEPTH*DATA_W-1:0]       io_async_mem,
   output logic [$clog2(DEPTH):0]        io_async_widx,
   input  logic [$clog2(DEPTH):0]        io_async_ridx,
   output logic                          io_async_safe_widx_valid,
   input  logic                          io_async_safe_ridx_valid,
   output logic                          io_async_safe_source_reset_n,
   input  logic                          io_async_safe_sink_reset_n,
   output logic [$clog2(DEPTH):0]        io_count,
   output logic                          io_hwm
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = AW + 1;
   localparam int PW = (AW > 0) ? AW : 1;
   localparam logic [IW-1:0] FULL_MASK = IW'(DEPTH | (DEPTH >> 1));

   logic [IW-1:0]     ridx_sync [SYNC];
   logic [SYNC-1:0]   ok_sync;
   logic [IW-1:0]     ridx_s;
   logic [IW-1:0]     ridx_bin;
   logic              sink_ok;

   logic [IW-1:0]     widx_bin;
   logic [IW-1:0]     widx_gray;
   logic [IW-1:0]     widx_bin_nxt;
   logic [IW-1:0]     count_nxt;
   logic [PW-1:0]     wptr;
   logic              full;
   logic              fire;
   logic              src_rst_q;
   logic              widx_valid_q;

   logic [DATA_W-1:0] mem [DEPTH];

   function automatic logic [IW-1:0] bin2gray(input logic [IW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [IW-1:0] gray2bin(input logic [IW-1:0] g);
      logic [IW-1:0] b;
      b = g;
      for (int unsigned i = 1; i < IW; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

   // Both async inputs go through SYNC flops before any use in this domain.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < SYNC; i++) begin
            ridx_sync[i] <= '0;
         end
         ok_sync <= '0;
      end else begin
         ridx_sync[0] <= io_async_ridx;
         for (int unsigned i = 1; i < SYNC; i++) begin
            ridx_sync[i] <= ridx_sync[i-1];
         end
         ok_sync <= {ok_sync[SYNC-2:0],
                     io_async_safe_ridx_valid & io_async_safe_sink_reset_n};
      end
   end

   assign ridx_s   = ridx_sync[SYNC-1];
   assign sink_ok  = ok_sync[SYNC-1];
   assign ridx_bin = gray2bin(ridx_s);

   // Reset status leads index validity by one edge so the sink sees a clean order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         src_rst_q    <= 1'b0;
         widx_valid_q <= 1'b0;
      end else begin
         src_rst_q    <= 1'b1;
         widx_valid_q <= src_rst_q;
      end
   end

   assign io_async_safe_source_reset_n = src_rst_q;
   assign io_async_safe_widx_valid     = widx_valid_q;

   always_comb begin
      full         = (widx_gray == (ridx_s ^ FULL_MASK));
      io_enq_ready = sink_ok & ~full & widx_valid_q;
      fire         = io_enq_valid & io_enq_ready;
      widx_bin_nxt = widx_bin + IW'(1);
      count_nxt    = widx_bin - ridx_bin;
      wptr         = PW'(widx_bin & IW'(DEPTH - 1));
   end

   // Loss of the sink rewinds the ring to index 0; stale entries stay in place.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         widx_bin  <= '0;
         widx_gray <= '0;
         io_count  <= '0;
         io_hwm    <= 1'b0;
      end else if (!sink_ok) begin
         widx_bin  <= '0;
         widx_gray <= '0;
         io_count  <= '0;
         io_hwm    <= 1'b0;
      end else begin
         if (fire) begin
            widx_bin  <= widx_bin_nxt;
            widx_gray <= bin2gray(widx_bin_nxt);
         end
         io_count <= count_nxt;
         io_hwm   <= (count_nxt >= IW'(HWM));
      end
   end

   assign io_async_widx = widx_gray;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (fire) begin
         mem[wptr] <= io_enq_bits;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_mem
      assign io_async_mem[g*DATA_W +: DATA_W] = mem[g];
   end

endmodule
